// File: rtl/torreta_engajamento_m.sv
// Sweep-and-engage sequencer: ping-pong servo sweep, one range measurement per
// dwell, threat confirmation over consecutive readings and a timed fire cycle.
module torreta_engajamento_m #(
  parameter int N_POS       = 29,
  parameter int W_POS       = 5,
  parameter int DWELL       = 20_000_000,
  parameter int W_DWELL     = 25,
  parameter int CONFIRM     = 2,
  parameter int AMMO_MAX    = 9,
  parameter int FIRE_CYCLES = 50_000_000,
  parameter int W_FIRE      = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             habilitar,
  input  logic [11:0]      medida,
  input  logic             medida_pronto,
  input  logic             medida_timeout,
  input  logic [11:0]      limiar,
  input  logic             recarregar,
  output logic             medir,
  output logic             transmitir,
  output logic [W_POS-1:0] posicao,
  output logic             direcao,
  output logic             ameaca,
  output logic             dispara,
  output logic [3:0]       municao,
  output logic             sem_municao,
  output logic [2:0]       db_estado
);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    MEDIR   = 3'd1,
    AGUARDA = 3'd2,
    DECIDE  = 3'd3,
    DISPARO = 3'd4,
    ESPERA  = 3'd5,
    GIRA    = 3'd6
  } estado_t;

  localparam int                 W_STREAK   = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [W_STREAK-1:0] STREAK_MAX = W_STREAK'(CONFIRM);
  localparam logic [W_POS-1:0]   POS_LAST   = W_POS'(N_POS - 1);
  localparam logic [W_DWELL-1:0] DWELL_LAST = W_DWELL'(DWELL - 1);
  localparam logic [W_FIRE-1:0]  FIRE_LAST  = W_FIRE'(FIRE_CYCLES - 1);
  localparam logic [3:0]         AMMO_FULL  = 4'(AMMO_MAX);

  estado_t             estado;
  logic [W_STREAK-1:0] streak;
  logic [W_STREAK-1:0] streak_sat;
  logic [W_DWELL-1:0]  dwell_cnt;
  logic [W_FIRE-1:0]   fire_cnt;
  logic                ameaca_medida;

  // Packed BCD compares correctly as a plain unsigned number; zero means no echo.
  assign ameaca_medida = (medida != 12'd0) && (medida < limiar);
  assign streak_sat    = (streak == STREAK_MAX) ? streak : streak + W_STREAK'(1);
  assign sem_municao   = (municao == 4'd0);
  assign db_estado     = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: dispara sits in the async branch, so reset drops it without waiting for an edge.
      estado     <= INICIAL;
      posicao    <= '0;
      direcao    <= 1'b0;
      ameaca     <= 1'b0;
      streak     <= '0;
      dwell_cnt  <= '0;
      fire_cnt   <= '0;
      municao    <= AMMO_FULL;
      medir      <= 1'b0;
      transmitir <= 1'b0;
      dispara    <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every branch below reads the pre-edge register values.
      medir      <= 1'b0;
      transmitir <= 1'b0;
      case (estado)
        INICIAL: begin
          if (habilitar) begin
            estado <= MEDIR;
            medir  <= 1'b1;
          end
        end
        MEDIR: estado <= AGUARDA;
        AGUARDA: begin
          if (medida_pronto) begin
            ameaca     <= ameaca_medida;
            transmitir <= 1'b1;
            estado     <= DECIDE;
          end else if (medida_timeout) begin
            ameaca     <= 1'b0;
            transmitir <= 1'b1;
            estado     <= DECIDE;
          end
        end
        DECIDE: begin
          dwell_cnt <= '0;
          fire_cnt  <= '0;
          if (!ameaca) begin
            streak <= '0;
            estado <= ESPERA;
          end else if (streak_sat == STREAK_MAX) begin
            if (municao != 4'd0) begin
              streak  <= streak_sat;
              dispara <= 1'b1;
              estado  <= DISPARO;
            end else begin
              streak <= '0;
              estado <= ESPERA;
            end
          end else begin
            streak <= streak_sat;
            medir  <= 1'b1;
            estado <= MEDIR;
          end
        end
        DISPARO: begin
          if (fire_cnt == FIRE_LAST) begin
            dispara   <= 1'b0;
            municao   <= municao - 4'd1;
            streak    <= '0;
            dwell_cnt <= '0;
            estado    <= ESPERA;
          end else begin
            fire_cnt <= fire_cnt + W_FIRE'(1);
          end
        end
        ESPERA: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            estado    <= habilitar ? GIRA : INICIAL;
          end else begin
            dwell_cnt <= dwell_cnt + W_DWELL'(1);
          end
        end
        GIRA: begin
          streak <= '0;
          medir  <= 1'b1;
          estado <= MEDIR;
          if (N_POS > 1) begin
            if (!direcao) begin
              if (posicao != POS_LAST) begin
                posicao <= posicao + W_POS'(1);
              end else begin
                posicao <= posicao - W_POS'(1);
                direcao <= 1'b1;
              end
            end else begin
              if (posicao != '0) begin
                posicao <= posicao - W_POS'(1);
              end else begin
                posicao <= posicao + W_POS'(1);
                direcao <= 1'b0;
              end
            end
          end
        end
        default: estado <= INICIAL;
      endcase
      // Placed last so a refill overrides the fire-end decrement.
      if (recarregar) municao <= AMMO_FULL;
    end
  end

endmodule

// File: tb/tb_torreta_engajamento_m.sv
// Bench for torreta_engajamento_m: the bench plays the range sensor, and a
// transaction-level model predicts position, threat, fire and ammunition per reading.
module tb_torreta_engajamento_m;

  localparam int         N_POS       = 4;
  localparam int         W_POS       = 2;
  localparam int         DWELL       = 4;
  localparam int         W_DWELL     = 3;
  localparam int         CONFIRM     = 2;
  localparam int         AMMO_MAX    = 2;
  localparam int         FIRE_CYCLES = 3;
  localparam int         W_FIRE      = 2;
  localparam logic [11:0] LIMIAR     = 12'h010;

  localparam int O_TO      = 1;   // assert medida_timeout
  localparam int O_NOPR    = 2;   // no medida_pronto
  localparam int O_RLD     = 4;   // recarregar pulse while waiting for the reading
  localparam int O_RLD_END = 8;   // recarregar on the fire-end cycle
  localparam int O_DROP    = 16;  // drop habilitar during the dwell
  localparam int O_RST     = 32;  // async reset right after dispara rises

  logic             clock = 1'b0;
  logic             reset;
  logic             habilitar;
  logic [11:0]      medida;
  logic             medida_pronto;
  logic             medida_timeout;
  logic [11:0]      limiar;
  logic             recarregar;
  logic             medir;
  logic             transmitir;
  logic [W_POS-1:0] posicao;
  logic             direcao;
  logic             ameaca;
  logic             dispara;
  logic [3:0]       municao;
  logic             sem_municao;
  logic [2:0]       db_estado;

  torreta_engajamento_m #(
    .N_POS(N_POS), .W_POS(W_POS), .DWELL(DWELL), .W_DWELL(W_DWELL),
    .CONFIRM(CONFIRM), .AMMO_MAX(AMMO_MAX), .FIRE_CYCLES(FIRE_CYCLES), .W_FIRE(W_FIRE)
  ) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .medida(medida),
    .medida_pronto(medida_pronto), .medida_timeout(medida_timeout), .limiar(limiar),
    .recarregar(recarregar), .medir(medir), .transmitir(transmitir), .posicao(posicao),
    .direcao(direcao), .ameaca(ameaca), .dispara(dispara), .municao(municao),
    .sem_municao(sem_municao), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int step_k;       // number of sweep steps taken since reset
  int streak;
  int ammo;
  int exp_gap;      // negedges until the next medir, <0 when unknown
  bit last_threat;
  bit aborted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ping-pong sweep position after k steps: triangle wave of period 2*(N_POS-1).
  function automatic int exp_pos(input int k);
    int p = 2 * (N_POS - 1);
    int m = k % p;
    return (m <= N_POS - 1) ? m : p - m;
  endfunction

  // Descending from the top turn-around until the bottom turn-around is left.
  function automatic int exp_dir(input int k);
    int p = 2 * (N_POS - 1);
    int m = k % p;
    return (k > 0 && (m == 0 || m > N_POS - 1)) ? 1 : 0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_estado"}, 32'(db_estado), 32'd0);
    check({tag, "_posicao"}, 32'(posicao), 32'd0);
    check({tag, "_direcao"}, 32'(direcao), 32'd0);
    check({tag, "_ameaca"}, 32'(ameaca), 32'd0);
    check({tag, "_medir"}, 32'(medir), 32'd0);
    check({tag, "_transmitir"}, 32'(transmitir), 32'd0);
    check({tag, "_dispara"}, 32'(dispara), 32'd0);
    check({tag, "_municao"}, 32'(municao), 32'(AMMO_MAX));
    check({tag, "_sem_municao"}, 32'(sem_municao), 32'd0);
  endtask

  // One full measurement transaction: wait for medir, answer, then follow the outcome.
  task automatic measure(input logic [11:0] val, input int opts);
    int n;
    int seen_fire;
    int count;
    int seen_medir;
    bit pr;
    bit threat;
    if (aborted) return;
    n = 0;
    seen_fire = 0;
    while (medir !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
      if (dispara === 1'b1) seen_fire++;
    end
    if (medir !== 1'b1) begin
      check("medir_seen", 32'(medir), 32'd1);
      aborted = 1'b1;
      return;
    end
    if (exp_gap >= 0) check("medir_gap", 32'(n), 32'(exp_gap));
    check("dispara_idle", 32'(seen_fire), 32'd0);
    check("posicao", 32'(posicao), 32'(exp_pos(step_k)));
    check("direcao", 32'(direcao), 32'(exp_dir(step_k)));
    check("ameaca_hold", 32'(ameaca), 32'(last_threat));

    @(negedge clock);
    check("medir_pulse", 32'(medir), 32'd0);
    if ((opts & O_RLD) != 0) begin
      recarregar = 1'b1;
      @(negedge clock);
      recarregar = 1'b0;
      ammo = AMMO_MAX;
      check("municao_rld", 32'(municao), 32'(ammo));
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);

    pr = ((opts & O_NOPR) == 0);
    medida         = val;
    medida_pronto  = pr;
    medida_timeout = ((opts & O_TO) != 0);
    @(negedge clock);
    medida_pronto  = 1'b0;
    medida_timeout = 1'b0;

    threat = pr && (val != 12'd0) && (val < LIMIAR);
    last_threat = threat;
    check("transmitir", 32'(transmitir), 32'd1);
    check("ameaca", 32'(ameaca), 32'(threat));
    check("municao", 32'(municao), 32'(ammo));
    check("sem_municao", 32'(sem_municao), 32'(ammo == 0));

    streak = threat ? ((streak + 1 > CONFIRM) ? CONFIRM : streak + 1) : 0;

    if (threat && streak == CONFIRM && ammo > 0) begin
      @(negedge clock);
      if ((opts & O_RST) != 0) begin
        check("dispara_rise", 32'(dispara), 32'd1);
        #2 reset = 1'b0;
        #1 check("dispara_async", 32'(dispara), 32'd0);
        check_reset_values("rst_fire");
        @(negedge clock);
        reset = 1'b1;
        step_k = 0;
        streak = 0;
        ammo = AMMO_MAX;
        last_threat = 1'b0;
        exp_gap = 1;
        return;
      end
      count = 0;
      while (dispara === 1'b1 && count < 10) begin
        count++;
        if (count == FIRE_CYCLES && (opts & O_RLD_END) != 0) recarregar = 1'b1;
        @(negedge clock);
        recarregar = 1'b0;
      end
      check("dispara_len", 32'(count), 32'(FIRE_CYCLES));
      ammo = ((opts & O_RLD_END) != 0) ? AMMO_MAX : ammo - 1;
      streak = 0;
      check("municao_fire", 32'(municao), 32'(ammo));
      check("sem_municao_fire", 32'(sem_municao), 32'(ammo == 0));
      step_k++;
      exp_gap = DWELL + 1;
    end else if (threat && streak < CONFIRM) begin
      exp_gap = 1;
    end else begin
      streak = 0;
      if ((opts & O_DROP) != 0) begin
        habilitar = 1'b0;
        seen_medir = 0;
        repeat (DWELL + 2) begin
          @(negedge clock);
          if (medir === 1'b1) seen_medir++;
        end
        check("drop_medir", 32'(seen_medir), 32'd0);
        check("drop_estado", 32'(db_estado), 32'd0);
        check("drop_posicao", 32'(posicao), 32'(exp_pos(step_k)));
        check("drop_direcao", 32'(direcao), 32'(exp_dir(step_k)));
        habilitar = 1'b1;
        exp_gap = 1;
      end else begin
        step_k++;
        exp_gap = DWELL + 2;
      end
    end
  endtask

  function automatic logic [11:0] random_bcd();
    logic [3:0] c = 4'($urandom_range(0, 9));
    logic [3:0] d = 4'($urandom_range(0, 9));
    logic [3:0] u = 4'($urandom_range(0, 9));
    return {c, d, u};
  endfunction

  // Directed opening: sweep, confirmation, broken streak, empty magazine, timeouts, refills.
  logic [11:0] dir_val [30] = '{
    12'h050, 12'h050, 12'h050, 12'h050, 12'h050, 12'h050, 12'h050, 12'h050,
    12'h005, 12'h005,
    12'h005, 12'h050, 12'h005,
    12'h050, 12'h000,
    12'h005, 12'h005,
    12'h005, 12'h005,
    12'h000, 12'h005,
    12'h050, 12'h005, 12'h005,
    12'h050,
    12'h050, 12'h005, 12'h005, 12'h050, 12'h050
  };
  int dir_opt [30] = '{
    0, 0, 0, 0, 0, 0, 0, 0,
    0, 0,
    0, 0, 0,
    0, 0,
    0, 0,
    0, 0,
    O_TO | O_NOPR, O_TO,
    O_RLD, 0, O_RLD_END,
    O_DROP,
    0, 0, 0, 0, 0
  };

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int opts;
    logic [11:0] val;
    reset          = 1'b0;
    habilitar      = 1'b0;
    medida         = 12'd0;
    medida_pronto  = 1'b0;
    medida_timeout = 1'b0;
    limiar         = LIMIAR;
    recarregar     = 1'b0;
    step_k = 0;
    streak = 0;
    ammo = AMMO_MAX;
    exp_gap = -1;
    last_threat = 1'b0;
    aborted = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_estado", 32'(db_estado), 32'd0);
    check("idle_medir", 32'(medir), 32'd0);
    habilitar = 1'b1;
    exp_gap = 1;

    for (int i = 0; i < 30; i++) measure(dir_val[i], dir_opt[i]);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      opts = 0;
      if (r < 45)      val = 12'h005;
      else if (r < 70) val = 12'h050;
      else if (r < 78) val = 12'h000;
      else if (r < 86) begin val = 12'h005; opts = O_TO | O_NOPR; end
      else if (r < 92) begin val = 12'h005; opts = O_TO; end
      else             val = random_bcd();
      if ($urandom_range(0, 9) == 0)  opts |= O_RLD;
      if ($urandom_range(0, 11) == 0) opts |= O_DROP;
      measure(val, opts);
    end

    // Clear any streak, refill, then reset in the middle of a confirmed shot.
    measure(12'h050, 0);
    measure(12'h005, O_RLD);
    measure(12'h005, O_RST);
    for (int i = 0; i < 6; i++) measure(($urandom_range(0, 1) == 0) ? 12'h005 : 12'h050, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
